mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Memory stage of the 5-stage core: consumes the EX/MEM pipeline register, performs loads/stores on
//  the data bus (req/ready address phase + rvalid response phase), aligns/extends load data, detects
//  misaligned accesses, and registers the MEM/WB pipeline entry. Stalls the pipeline while a bus access is open.
// PARAMETERS
//  DATA_W  32  data bus / register width (only 32 supported)
//  ADDR_W  32  data bus address width
// PORTS
//  clk             in   1       core clock
//  rst             in   1       synchronous active-high reset
//  mem_flush       in   1       kill instruction in MEM; no WB entry, no new bus request
//  in_valid        in   1       EX/MEM entry valid
//  in_mem_read     in   1       load
//  in_mem_write    in   1       store
//  in_reg_write    in   1       writes rd
//  in_reg_regid    in   5       rd index
//  in_mem_opcode   in   3       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  in_alu_out      in   DATA_W  effective address, or result for non-memory ops
//  in_mem_writedata in  DATA_W  store data (rs2)
//  in_pc           in   ADDR_W  instruction PC (carried to WB for traps)
//  dbus_req        out  1       address-phase request
//  dbus_write      out  1       1 store, 0 load
//  dbus_addr       out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dbus_wdata      out  DATA_W  store data replicated into byte lanes
//  dbus_byteen     out  4       byte enables
//  dbus_ready      in   1       address phase accepted this cycle
//  dbus_rvalid     in   1       load response valid
//  dbus_rdata      in   DATA_W  load response word
//  mem_stall_req   out  1       combinational: hold EX/MEM register this cycle
//  wb_valid, wb_reg_write out 1 MEM/WB control;  wb_regid out 5;  wb_data out DATA_W;  wb_pc out ADDR_W
//  wb_exc_load_misaligned, wb_exc_store_misaligned out 1;  wb_exc_addr out ADDR_W  faulting address
// BEHAVIOUR
//  Reset: FSM=IDLE, kill=0, all wb_* =0; dbus_req=0, mem_stall_req=0.
//  Misaligned: H with addr[0]!=0, W with addr[1:0]!=0 -> no bus request, exc flag + addr registered to WB,
//   wb_reg_write=0. Byteen: B 4'b0001<<addr[1:0]; H addr[1]?1100:0011; W 1111. wdata: B {4{d[7:0]}}, H {2{d[15:0]}}.
//  Load data: select lane by addr[1:0]; sign-extend B/H, zero-extend BU/HU. Undefined opcodes: treat as W.
//  FSM (access = in_valid & (rd|wr) & aligned & ~mem_flush):
//   IDLE: dbus_req=access. Store & ready -> done this cycle, stall=0. Load & ready -> RESP, stall=1.
//         ~ready -> REQ, stall=1.
//   REQ : dbus_req=1, address/data from inputs (held stable by stall). ready: store -> IDLE stall=0;
//         load -> RESP stall=1. ~ready: stay, stall=1.
//   RESP: dbus_req=0; stall=~dbus_rvalid. rvalid -> capture aligned data into WB, -> IDLE.
//  dbus_rvalid in IDLE/REQ is ignored. Only one access outstanding; req never held two accesses.
//  WB register loads when ~mem_stall_req: non-memory op -> wb_data=in_alu_out; load -> aligned rdata;
//   store -> wb_reg_write=0. While stalled, a bubble (wb_valid=0, all ctrl 0) is written each cycle.
//  Flush: in IDLE suppresses request and writes bubble. In REQ/RESP sets kill: bus access runs to
//   completion (req held until ready, response consumed), stall stays asserted until completion,
//   completion writes bubble, kill cleared. Flush never drops a request mid address phase.
//  Reset mid-access: FSM->IDLE immediately, dbus_req=0, pending response discarded.
//  in_valid=0 -> bubble, no request regardless of ctrl bits.
// TESTING
//  LW addr 0x104, ready same cycle, rvalid next cycle rdata=0xDEADBEEF -> stall 1 cycle, wb_data=0xDEADBEEF.
//  LB addr 0x103 rdata=0x80FF_FF7F -> byteen n/a, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x102 data 0x1234ABCD, ready held 0 for 3 cycles -> dbus_req 4 cycles, byteen 1100,
//   wdata 0xABCDABCD, stall 3 cycles, wb_reg_write=0.
//  LW addr 0x101 -> no dbus_req, wb_exc_load_misaligned=1, wb_exc_addr=0x101, no stall.
//  LW issued, mem_flush in RESP, rvalid 2 cycles later -> stall until rvalid, then wb_valid=0, no write.
//  rst asserted in REQ -> next cycle dbus_req=0, mem_stall_req=0, wb_* =0, late rvalid ignored.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: memory stage - drives the data bus for loads/stores, aligns load data, flags misaligned
// accesses and registers the MEM/WB entry, stalling the pipeline while a bus access is open.
module mem_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_flush,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic [4:0]        in_reg_regid,
    input  logic [2:0]        in_mem_opcode,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_mem_writedata,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              dbus_req,
    output logic              dbus_write,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [DATA_W-1:0] dbus_wdata,
    output logic [3:0]        dbus_byteen,
    input  logic              dbus_ready,
    input  logic              dbus_rvalid,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic              mem_stall_req,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_regid,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_pc,
    output logic              wb_exc_load_misaligned,
    output logic              wb_exc_store_misaligned,
    output logic [ADDR_W-1:0] wb_exc_addr
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_n;
    logic kill, kill_n;
    logic is_b, is_h, is_w, is_uns, mem_op, is_store, mis, access, wb_ok;
    logic [DATA_W-1:0] sh, ld;

    assign is_b     = in_mem_opcode[1:0] == 2'b00;
    assign is_h     = in_mem_opcode[1:0] == 2'b01;
    assign is_w     = ~is_b & ~is_h;
    assign is_uns   = in_mem_opcode[2];
    assign mem_op   = in_valid & (in_mem_read | in_mem_write);
    assign is_store = in_mem_write & ~in_mem_read;
    assign mis      = (is_h & in_alu_out[0]) | (is_w & |in_alu_out[1:0]);
    assign access   = mem_op & ~mis & ~mem_flush;
    assign wb_ok    = in_valid & ~mem_flush & ~kill;

    assign sh = dbus_rdata >> {in_alu_out[1:0], 3'b000};
    assign ld = is_b ? {{(DATA_W-8){~is_uns & sh[7]}}, sh[7:0]} :
                is_h ? {{(DATA_W-16){~is_uns & sh[15]}}, sh[15:0]} : dbus_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_n;
            kill  <= kill_n;
        end
    end

    // kill remembers a flush that arrived while an access was open, until that access completes
    always_comb begin
        state_n = state;
        kill_n  = 1'b0;
        case (state)
            IDLE: state_n = access ? (dbus_ready ? (is_store ? IDLE : RESP) : REQ) : IDLE;
            REQ: begin
                state_n = dbus_ready ? (is_store ? IDLE : RESP) : REQ;
                kill_n  = ~(dbus_ready & is_store) & (kill | mem_flush);
            end
            RESP: begin
                state_n = dbus_rvalid ? IDLE : RESP;
                kill_n  = ~dbus_rvalid & (kill | mem_flush);
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        dbus_req      = ~rst & ((state == REQ) | ((state == IDLE) & access));
        mem_stall_req = ~rst & ((state == IDLE) ? access & ~(is_store & dbus_ready) :
                                (state == REQ)  ? ~(is_store & dbus_ready) : ~dbus_rvalid);
        dbus_write    = is_store;
        dbus_addr     = {in_alu_out[ADDR_W-1:2], 2'b00};
        dbus_byteen   = is_b ? 4'b0001 << in_alu_out[1:0] : is_h ? (in_alu_out[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        dbus_wdata    = is_b ? {4{in_mem_writedata[7:0]}} : is_h ? {2{in_mem_writedata[15:0]}} : in_mem_writedata;
    end

    always_ff @(posedge clk) begin
        if (rst | mem_stall_req) begin
            wb_valid                <= 1'b0;
            wb_reg_write            <= 1'b0;
            wb_regid                <= '0;
            wb_data                 <= '0;
            wb_pc                   <= '0;
            wb_exc_load_misaligned  <= 1'b0;
            wb_exc_store_misaligned <= 1'b0;
            wb_exc_addr             <= '0;
        end else begin
            wb_valid                <= wb_ok;
            wb_reg_write            <= wb_ok & in_reg_write & ~is_store & ~(mem_op & mis);
            wb_regid                <= wb_ok ? in_reg_regid : '0;
            wb_data                 <= wb_ok ? ((in_mem_read & ~mis) ? ld : in_alu_out) : '0;
            wb_pc                   <= wb_ok ? in_pc : '0;
            wb_exc_load_misaligned  <= wb_ok & mem_op & mis & in_mem_read;
            wb_exc_store_misaligned <= wb_ok & mem_op & mis & is_store;
            wb_exc_addr             <= (wb_ok & mem_op & mis) ? in_alu_out[ADDR_W-1:0] : '0;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized and directed checks of mem_lsu against a behavioural memory-stage model.
module tb_mem_lsu;
    logic        clk = 0, rst = 1, mem_flush = 0, in_valid = 0, in_mem_read = 0, in_mem_write = 0, in_reg_write = 0;
    logic [4:0]  in_reg_regid = 0;
    logic [2:0]  in_mem_opcode = 0;
    logic [31:0] in_alu_out = 0, in_mem_writedata = 0, in_pc = 0;
    logic        dbus_req, dbus_write, dbus_ready = 0, dbus_rvalid = 0, mem_stall_req;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = 0;
    logic [3:0]  dbus_byteen;
    logic        wb_valid, wb_reg_write, wb_exc_load_misaligned, wb_exc_store_misaligned;
    logic [4:0]  wb_regid;
    logic [31:0] wb_data, wb_pc, wb_exc_addr;
    int checks = 0, errors = 0;

    mem_lsu dut (
        .clk(clk), .rst(rst), .mem_flush(mem_flush), .in_valid(in_valid), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_reg_write(in_reg_write), .in_reg_regid(in_reg_regid),
        .in_mem_opcode(in_mem_opcode), .in_alu_out(in_alu_out), .in_mem_writedata(in_mem_writedata),
        .in_pc(in_pc), .dbus_req(dbus_req), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_byteen(dbus_byteen), .dbus_ready(dbus_ready),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .mem_stall_req(mem_stall_req),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_regid(wb_regid), .wb_data(wb_data),
        .wb_pc(wb_pc), .wb_exc_load_misaligned(wb_exc_load_misaligned),
        .wb_exc_store_misaligned(wb_exc_store_misaligned), .wb_exc_addr(wb_exc_addr)
    );

    always #5 clk = ~clk;

    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] r);
        logic [7:0] b;
        logic [15:0] h;
        b = r[8*a[1:0] +: 8];
        h = r[16*a[1] +: 16];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return r;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] a);
        int n;
        n = size_of(op);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] op, input logic [31:0] d);
        int n;
        n = size_of(op);
        return n == 1 ? {4{d[7:0]}} : n == 2 ? {2{d[15:0]}} : d;
    endfunction

    task automatic drive_idle();
        in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0;
        dbus_ready = 0; dbus_rvalid = 0; mem_flush = 0;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic regw, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                             input int rdy_dly, input int rv_dly, input string nm);
        int n, reqs, stalls, exp_reqs, exp_stalls;
        logic memop, mis, fin, exp_rw;
        logic [4:0] rid;
        logic [31:0] pc;
        n = size_of(op);
        memop = rd | wr;
        mis = memop && (a % n != 0);
        exp_reqs = (memop && !mis) ? rdy_dly + 1 : 0;
        exp_stalls = (memop && !mis) ? (rd ? rdy_dly + 1 + rv_dly : rdy_dly) : 0;
        exp_rw = !memop ? regw : (rd && !mis) ? regw : 1'b0;
        rid = 5'($urandom);
        pc = $urandom;
        @(negedge clk);
        in_valid = 1; in_mem_read = rd; in_mem_write = wr; in_reg_write = regw; in_reg_regid = rid;
        in_mem_opcode = op; in_alu_out = a; in_mem_writedata = wd; in_pc = pc;
        reqs = 0; stalls = 0; fin = 0;
        for (int k = 0; k < 64 && !fin; k++) begin
            dbus_ready = (k == rdy_dly);
            dbus_rvalid = rd && (k == rdy_dly + 1 + rv_dly);
            dbus_rdata = dbus_rvalid ? rdat : $urandom;
            #1;
            if (dbus_req) begin
                reqs++;
                checks++;
                if ({dbus_write, dbus_addr, dbus_byteen, dbus_wdata} !== {wr & ~rd, a & ~32'h3, model_be(op, a), model_wd(op, wd)}) begin
                    errors++;
                    $display("FAIL %s bus: got w=%0b addr=%h be=%b wd=%h want w=%0b addr=%h be=%b wd=%h", nm,
                             dbus_write, dbus_addr, dbus_byteen, dbus_wdata, wr & ~rd, a & ~32'h3, model_be(op, a), model_wd(op, wd));
                end
            end
            if (mem_stall_req) stalls++; else fin = 1;
            @(posedge clk); #1;
            if (!fin) @(negedge clk);
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL %s timeout: stall never released", nm); end
        checks++;
        if (reqs != exp_reqs) begin errors++; $display("FAIL %s req_cycles: got %0d want %0d", nm, reqs, exp_reqs); end
        checks++;
        if (stalls != exp_stalls) begin errors++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, exp_stalls); end
        checks++;
        if ({wb_valid, wb_reg_write, wb_regid, wb_pc} !== {1'b1, exp_rw, rid, pc}) begin
            errors++;
            $display("FAIL %s wb_ctrl: got v=%0b rw=%0b id=%0d pc=%h want v=1 rw=%0b id=%0d pc=%h", nm,
                     wb_valid, wb_reg_write, wb_regid, wb_pc, exp_rw, rid, pc);
        end
        checks++;
        if ({wb_exc_load_misaligned, wb_exc_store_misaligned, wb_exc_addr} !== {mis & rd, mis & wr & ~rd, mis ? a : 32'h0}) begin
            errors++;
            $display("FAIL %s wb_exc: got l=%0b s=%0b addr=%h want l=%0b s=%0b addr=%h", nm, wb_exc_load_misaligned,
                     wb_exc_store_misaligned, wb_exc_addr, mis & rd, mis & wr & ~rd, mis ? a : 32'h0);
        end
        if (!memop || (rd && !mis)) begin
            checks++;
            if (wb_data !== (rd ? model_load(op, a, rdat) : a)) begin
                errors++;
                $display("FAIL %s wb_data: got %h want %h", nm, wb_data, rd ? model_load(op, a, rdat) : a);
            end
        end
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; in_mem_read = 1; in_mem_opcode = 3'b010; in_alu_out = 32'h40;
        @(negedge clk); #1;
        checks++;
        if ({dbus_req, mem_stall_req} !== 2'b00) begin errors++; $display("FAIL reset_bus: got req=%0b stall=%0b want 0 0", dbus_req, mem_stall_req); end
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, wb_reg_write, wb_regid, wb_data, wb_pc, wb_exc_load_misaligned, wb_exc_store_misaligned, wb_exc_addr} !== '0) begin
            errors++; $display("FAIL reset_wb: got v=%0b data=%h pc=%h want all 0", wb_valid, wb_data, wb_pc);
        end
        drive_idle();
        @(negedge clk); rst = 0;
    endtask

    task automatic test_directed();
        do_access(1, 0, 1, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0, "lw");
        do_access(1, 0, 1, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 0, 0, "lb");
        checks++;
        if (wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_const: got %h want ffffff80", wb_data); end
        do_access(1, 0, 1, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1, "lbu");
        checks++;
        if (wb_data !== 32'h00000080) begin errors++; $display("FAIL lbu_const: got %h want 00000080", wb_data); end
        do_access(0, 1, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 3, 0, "sh");
        do_access(1, 0, 1, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, "lw_mis");
        do_access(0, 1, 0, 3'b001, 32'h203, 32'h55, 32'h0, 0, 0, "sh_mis");
        do_access(0, 0, 1, 3'b000, 32'hCAFE0001, 32'h0, 32'h0, 0, 0, "alu");
        do_access(1, 0, 1, 3'b101, 32'h302, 32'h0, 32'h9ABC1234, 2, 2, "lhu");
    endtask

    task automatic test_invalid();
        @(negedge clk);
        in_valid = 0; in_mem_read = 1; in_mem_write = 1; in_reg_write = 1; in_alu_out = 32'h500; dbus_ready = 1;
        #1;
        checks++;
        if ({dbus_req, mem_stall_req} !== 2'b00) begin errors++; $display("FAIL invalid_bus: got req=%0b stall=%0b want 0 0", dbus_req, mem_stall_req); end
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, wb_reg_write} !== 2'b00) begin errors++; $display("FAIL invalid_wb: got v=%0b rw=%0b want 0 0", wb_valid, wb_reg_write); end
        drive_idle();
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_mem_opcode = 3'b010; in_alu_out = 32'h600; mem_flush = 1; dbus_ready = 1;
        #1;
        checks++;
        if ({dbus_req, mem_stall_req} !== 2'b00) begin errors++; $display("FAIL flush_idle_bus: got req=%0b stall=%0b want 0 0", dbus_req, mem_stall_req); end
        @(posedge clk); #1;
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_wb: got v=%0b want 0", wb_valid); end
        drive_idle();
    endtask

    task automatic test_flush_resp();
        @(negedge clk);
        in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_mem_opcode = 3'b010; in_alu_out = 32'h200; dbus_ready = 1;
        #1;
        checks++;
        if ({dbus_req, mem_stall_req} !== 2'b11) begin errors++; $display("FAIL flush_resp_issue: got req=%0b stall=%0b want 1 1", dbus_req, mem_stall_req); end
        @(negedge clk);
        dbus_ready = 0; mem_flush = 1;
        #1;
        checks++;
        if ({dbus_req, mem_stall_req} !== 2'b01) begin errors++; $display("FAIL flush_resp_hold: got req=%0b stall=%0b want 0 1", dbus_req, mem_stall_req); end
        @(negedge clk);
        mem_flush = 0;
        #1;
        checks++;
        if (mem_stall_req !== 1'b1) begin errors++; $display("FAIL flush_resp_kill: got stall=%0b want 1", mem_stall_req); end
        @(negedge clk);
        dbus_rvalid = 1; dbus_rdata = 32'h11112222;
        #1;
        checks++;
        if (mem_stall_req !== 1'b0) begin errors++; $display("FAIL flush_resp_done: got stall=%0b want 0", mem_stall_req); end
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, wb_reg_write} !== 2'b00) begin errors++; $display("FAIL flush_resp_wb: got v=%0b rw=%0b want 0 0", wb_valid, wb_reg_write); end
        drive_idle();
        @(negedge clk); #1;
        checks++;
        if ({dbus_req, mem_stall_req} !== 2'b00) begin errors++; $display("FAIL flush_resp_idle: got req=%0b stall=%0b want 0 0", dbus_req, mem_stall_req); end
    endtask

    task automatic test_flush_req();
        int reqs = 0;
        @(negedge clk);
        in_valid = 1; in_mem_write = 1; in_mem_opcode = 3'b010; in_alu_out = 32'h700; in_mem_writedata = 32'h77;
        for (int k = 0; k < 3; k++) begin
            dbus_ready = (k == 2);
            mem_flush = (k == 1);
            #1;
            if (dbus_req) reqs++;
            if (k < 2) begin
                checks++;
                if (mem_stall_req !== 1'b1) begin errors++; $display("FAIL flush_req_stall%0d: got %0b want 1", k, mem_stall_req); end
            end
            @(negedge clk);
        end
        checks++;
        if (reqs != 3) begin errors++; $display("FAIL flush_req_held: got %0d want 3", reqs); end
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_req_wb: got v=%0b want 0", wb_valid); end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_mem_opcode = 3'b010; in_alu_out = 32'h300; dbus_ready = 0;
        @(negedge clk);
        rst = 1; drive_idle();
        @(posedge clk); #1;
        rst = 0;
        #1;
        checks++;
        if ({dbus_req, mem_stall_req, wb_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_mid: got req=%0b stall=%0b v=%0b want 0 0 0", dbus_req, mem_stall_req, wb_valid);
        end
        @(negedge clk);
        dbus_rvalid = 1; dbus_rdata = 32'h33334444;
        #1;
        checks++;
        if (mem_stall_req !== 1'b0) begin errors++; $display("FAIL reset_late_rvalid: got stall=%0b want 0", mem_stall_req); end
        @(posedge clk); #1;
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_late_wb: got v=%0b want 0", wb_valid); end
        drive_idle();
        do_access(1, 0, 1, 3'b010, 32'h304, 32'h0, 32'h0BADF00D, 1, 0, "after_rst");
    endtask

    task automatic test_random();
        logic [2:0] ops [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
        for (int i = 0; i < 40; i++) begin
            int sel, n;
            logic [2:0] op;
            logic [31:0] a;
            sel = $urandom_range(0, 2);
            op = ops[$urandom_range(0, 6)];
            n = size_of(op);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
            do_access(sel == 0, sel == 1, 1'($urandom), op, a, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invalid();
        test_flush_idle();
        test_flush_resp();
        test_flush_req();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
